// File: rtl/aes_block_fifo.sv
// First-word-fall-through FIFO of AES state blocks (four rows per block) with
// occupancy status, almost-full threshold, sticky overflow/underflow flags and flush.
module aes_block_fifo #(
  parameter int ROW_W     = 32,
  parameter int NROWS     = 4,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       err_clr,
  input  logic                       wen,
  input  logic [ROW_W-1:0]           in_row0,
  input  logic [ROW_W-1:0]           in_row1,
  input  logic [ROW_W-1:0]           in_row2,
  input  logic [ROW_W-1:0]           in_row3,
  input  logic                       ren,
  output logic [ROW_W-1:0]           out_row0,
  output logic [ROW_W-1:0]           out_row1,
  output logic [ROW_W-1:0]           out_row2,
  output logic [ROW_W-1:0]           out_row3,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = NROWS * ROW_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_udf;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_udf_set;
  logic [BW-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // flush swallows both strobes, so nothing is stored and no error is flagged that cycle
  assign w_push    = wen && (!w_full || ren) && !flush;
  assign w_pop     = ren && !w_empty && !flush;
  assign w_ovf_set = wen && w_full && !ren && !flush;
  assign w_udf_set = ren && w_empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // a new error in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !err_clr) || w_ovf_set;
      r_udf <= (r_udf && !err_clr) || w_udf_set;
    end
  end

  // storage is intentionally left unreset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_row3, in_row2, in_row1, in_row0};
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign out_row0    = w_head[0*ROW_W +: ROW_W];
  assign out_row1    = w_head[1*ROW_W +: ROW_W];
  assign out_row2    = w_head[2*ROW_W +: ROW_W];
  assign out_row3    = w_head[3*ROW_W +: ROW_W];
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= AFULL_C);
  assign count       = r_count;
  assign ovf_err     = r_ovf;
  assign udf_err     = r_udf;

endmodule
